// File: rtl/ysyx_22050039_mcyc_ctrl.sv
// ysyx_22050039_mcyc_ctrl: multi-cycle core sequencer owning PC and instruction register.
// Define YSYX_22050039_PERF_EN to implement the cycle_cnt/instret counters.
module ysyx_22050039_mcyc_ctrl #(
  parameter int XLEN = 64,
  parameter int INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_LEN-1:0] imem_rsp_data,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     pc,
  input  logic                dec_mem,
  input  logic                dec_rd_wen,
  input  logic                dec_halt,
  input  logic [XLEN-1:0]     dnpc,
  output logic                dmem_req_valid,
  input  logic                dmem_req_ready,
  input  logic                dmem_rsp_valid,
  output logic                rf_wen,
  output logic                pc_wen,
  output logic                halted,
  output logic                bad_pc,
  output logic [63:0]         cycle_cnt,
  output logic [63:0]         instret
);
  typedef enum logic [2:0] {FETCH, FWAIT, DECODE, EXEC, MREQ, MWAIT, WB, HALT} state_e;
  state_e state_q;
  logic [XLEN-1:0] pc_q;
  logic [INST_LEN-1:0] inst_q;
  logic bad_pc_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      inst_q <= '0;
      bad_pc_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: if (imem_req_ready) state_q <= FWAIT;
        FWAIT: if (imem_rsp_valid) begin
          inst_q <= imem_rsp_data;
          state_q <= DECODE;
        end
        DECODE: state_q <= dec_halt ? HALT : EXEC;
        EXEC: if (dnpc[1:0] != 2'b00) begin
          bad_pc_q <= 1'b1;
          state_q <= HALT;
        end else state_q <= dec_mem ? MREQ : WB;
        MREQ: if (dmem_req_ready) state_q <= MWAIT;
        MWAIT: if (dmem_rsp_valid) state_q <= WB;
        WB: begin
          pc_q <= dnpc;
          state_q <= FETCH;
        end
        default: state_q <= HALT;
      endcase
    end
  end
  // The fetch request is masked while reset is held so no request leaks out during reset.
  assign imem_req_valid = rst && state_q == FETCH;
  assign dmem_req_valid = state_q == MREQ;
  assign pc_wen = state_q == WB;
  assign rf_wen = state_q == WB && dec_rd_wen;
  assign halted = state_q == HALT;
  assign bad_pc = bad_pc_q;
  assign pc = pc_q;
  assign imem_addr = pc_q;
  assign inst = inst_q;
`ifdef YSYX_22050039_PERF_EN
  logic [63:0] cycle_q, instret_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (pc_wen) instret_q <= instret_q + 64'd1;
    end
  end
  assign cycle_cnt = cycle_q;
  assign instret = instret_q;
`else
  assign cycle_cnt = '0;
  assign instret = '0;
`endif
endmodule
